// File: rtl/sdrc_wb_pkg.sv
// Shared types and constants for the SDRAM-controller Wishbone burst master.
package sdrc_wb_pkg;

  localparam int APP_AW_DEF = 26;
  localparam int DW_DEF     = 32;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_FIN
  } wb_state_e;

endpackage

// File: rtl/sdrc_wb_beat_ctr.sv
// Loadable beat down-counter with last (one left) and zero flags.
module sdrc_wb_beat_ctr #(
  parameter int LENW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [LENW-1:0] load_val_i,
  input  logic            dec_i,
  output logic [LENW-1:0] remaining_o,
  output logic            last_o,
  output logic            zero_o
);

  logic [LENW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign remaining_o = cnt_q;
  assign last_o      = (cnt_q == LENW'(1));
  assign zero_o      = (cnt_q == '0);

endmodule

// File: rtl/sdrc_wb_burst_master.sv
// Command/data stream to Wishbone B3 incrementing-burst master.
module sdrc_wb_burst_master
  import sdrc_wb_pkg::*;
#(
  parameter int APP_AW = APP_AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int BW     = DW / 8,
  parameter int LENW   = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LENW-1:0]   cmd_len,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [DW-1:0]     wdat_data,
  input  logic [BW-1:0]     wdat_sel,
  output logic              rdat_valid,
  output logic [DW-1:0]     rdat_data,
  output logic              done,
  output logic              busy,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [BW-1:0]     wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i
);

  wb_state_e         state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              single_q, single_d;
  logic              rvld_q, rvld_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [BW-1:0]     sel_q, sel_d;
  logic [DW-1:0]     rdat_q, rdat_d;

  logic              ctr_load, ctr_dec;
  logic [LENW-1:0]   ctr_rem;
  logic              ctr_last, ctr_zero;
  logic              beat_ack;

  sdrc_wb_beat_ctr #(
    .LENW (LENW)
  ) u_beat_ctr (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .load_i      (ctr_load),
    .load_val_i  (cmd_len),
    .dec_i       (ctr_dec),
    .remaining_o (ctr_rem),
    .last_o      (ctr_last),
    .zero_o      (ctr_zero)
  );

  assign beat_ack = stb_q && wb_ack_i;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    busy_d     = busy_q;
    single_d   = single_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    rvld_d     = 1'b0;
    rdat_d     = rdat_q;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    cmd_ready  = 1'b0;
    wdat_ready = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = !wb_rst_i;
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            state_d = S_FIN;
          end else begin
            addr_d   = cmd_addr;
            we_d     = cmd_we;
            single_d = (cmd_len == LENW'(1));
            ctr_load = 1'b1;
            busy_d   = 1'b1;
            cyc_d    = 1'b1;
            if (cmd_we) begin
              state_d = S_LOAD;
            end else begin
              stb_d   = 1'b1;
              sel_d   = '1;
              state_d = S_XFER;
            end
          end
        end
      end
      S_LOAD: begin
        wdat_ready = 1'b1;
        if (wdat_valid) begin
          dat_d   = wdat_data;
          sel_d   = wdat_sel;
          stb_d   = 1'b1;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (ctr_zero) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_FIN;
        end else if (beat_ack) begin
          addr_d  = addr_q + APP_AW'(BW);
          ctr_dec = 1'b1;
          if (!we_q) begin
            rvld_d = 1'b1;
            rdat_d = wb_dat_i;
          end
          if (ctr_last) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            state_d = S_FIN;
          end else if (we_q && (ctr_rem > LENW'(1))) begin
            // next beat may be taken in the ack cycle for a zero-bubble strobe
            wdat_ready = 1'b1;
            if (wdat_valid) begin
              dat_d = wdat_data;
              sel_d = wdat_sel;
            end else begin
              stb_d   = 1'b0;
              state_d = S_LOAD;
            end
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      single_q <= 1'b0;
      rvld_q   <= 1'b0;
      addr_q   <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      single_q <= single_d;
      rvld_q   <= rvld_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      rdat_q   <= rdat_d;
    end
  end

  always_comb begin
    wb_cti_o = CTI_CLASSIC;
    if (stb_q && !single_q) begin
      wb_cti_o = ctr_last ? CTI_EOB : CTI_INCR;
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_addr_o  = addr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign busy       = busy_q;
  assign rdat_valid = rvld_q;
  assign rdat_data  = rdat_q;

endmodule

// File: tb/tb_sdrc_wb_burst_master.sv
// Self-checking bench: directed table, corner sequences, random commands.
module tb_sdrc_wb_burst_master;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdat_valid, wdat_ready;
  logic [DW-1:0] wdat_data;
  logic [BW-1:0] wdat_sel;
  logic          rdat_valid;
  logic [DW-1:0] rdat_data;
  logic          done, busy;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [BW-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;

  always #5 clk = ~clk;

  sdrc_wb_burst_master #(
    .APP_AW (AW),
    .DW     (DW),
    .BW     (BW),
    .LENW   (LW)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wdat_valid (wdat_valid),
    .wdat_ready (wdat_ready),
    .wdat_data  (wdat_data),
    .wdat_sel   (wdat_sel),
    .rdat_valid (rdat_valid),
    .rdat_data  (rdat_data),
    .done       (done),
    .busy       (busy),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_addr_o  (wb_addr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_cti_o   (wb_cti_o),
    .wb_ack_i   (wb_ack_i),
    .wb_dat_i   (wb_dat_i)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [BW-1:0] s;
    int            gap;
  } wbeat_t;

  typedef struct {
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] d;
    logic [BW-1:0] s;
    logic [2:0]    cti;
  } bbeat_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] a;
    int            len;
    int            dly;
    int            gi;
    int            gn;
    logic [DW-1:0] d0;
    logic [BW-1:0] s0;
    logic [2:0]    c_first;
    logic [2:0]    c_last;
    int            cyc;
    int            gapc;
    logic [AW-1:0] end_a;
  } vec_t;

  wbeat_t        wq[$];
  wbeat_t        wexp[$];
  bbeat_t        beats[$];
  logic [DW-1:0] rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int hold = 0;
  int ack_dly = 0;
  int wait_c = 0;
  bit spur_en = 1'b0;
  bit cur_we = 1'b0;
  int wr_hs = 0;
  int cyc_cnt = 0;
  int gap_cnt = 0;
  int last_hi = 0;
  int done_at = 0;
  int done_cnt = 0;
  logic [DW-1:0] rd_ctr = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // slave, write-data source and per-cycle monitor
  initial begin
    wb_ack_i   = 1'b0;
    wb_dat_i   = '0;
    wdat_valid = 1'b0;
    wdat_data  = '0;
    wdat_sel   = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (rdat_valid) begin
        chk("rdat_pending", 64'(rq.size() > 0), 1);
        if (rq.size() > 0) chk("rdat_data", rdat_data, rq.pop_front());
      end
      if (wb_cyc_o && wb_stb_o && !rst) begin
        if (wait_c >= ack_dly) begin
          wb_ack_i = 1'b1;
          wait_c   = 0;
          wb_dat_i = rd_ctr;
          rd_ctr   = rd_ctr + 1'b1;
        end else begin
          wb_ack_i = 1'b0;
          wait_c++;
        end
      end else begin
        wb_ack_i = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
        wait_c   = 0;
      end
      if (hold > 0) begin
        wdat_valid = 1'b0;
        hold--;
      end else if (wq.size() > 0) begin
        wdat_valid = 1'b1;
        wdat_data  = wq[0].d;
        wdat_sel   = wq[0].s;
      end else begin
        wdat_valid = 1'b0;
      end
      #1;
      if (wdat_valid && wdat_ready) begin
        wq.delete(0);
        wr_hs++;
        if (wq.size() > 0) hold = wq[0].gap;
      end
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
        beats.push_back('{wb_addr_o, wb_we_o, wb_dat_o, wb_sel_o, wb_cti_o});
        if (!wb_we_o) rq.push_back(wb_dat_i);
      end
      if (wb_cyc_o) begin
        cyc_cnt++;
        last_hi = cyc_n;
      end
      if (wb_cyc_o && !wb_stb_o) begin
        gap_cnt++;
        chk("cti_no_stb", wb_cti_o, 0);
      end
      if (wb_stb_o) chk("stb_needs_cyc", wb_cyc_o, 1);
      if (wdat_ready) chk("wdat_ready_only_write", cur_we, 1);
      if (done) begin
        done_cnt++;
        done_at = cyc_n;
      end
    end
  end

  task automatic setup(input bit we, input int n, input int gi, input int gn,
                       input int dly, input bit spur, input bit rgap);
    wq.delete();
    wexp.delete();
    beats.delete();
    rq.delete();
    for (int i = 0; i < n; i++) begin
      wbeat_t b;
      b.d   = $urandom;
      b.s   = 4'($urandom_range(1, 15));
      b.gap = rgap ? $urandom_range(0, 3) : ((i == gi) ? gn : 0);
      if (we) begin
        wq.push_back(b);
        wexp.push_back(b);
      end
    end
    hold    = 0;
    cur_we  = we;
    ack_dly = dly;
    spur_en = spur;
    wr_hs   = 0;
    cyc_cnt = 0;
    gap_cnt = 0;
    rd_ctr  = spur ? DW'($urandom) : '0;
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a,
                       input logic [LW-1:0] l);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = l;
    for (int k = 0; k < 20 && !acc; k++) begin
      #2;
      if (cmd_ready) acc = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed %0b need 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(negedge clk);
      #2;
      if (done_cnt != d0) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL done_timeout: done count %0d need %0d", done_cnt, d0 + 1);
    end
  endtask

  task automatic check_model(input bit we, input logic [AW-1:0] a,
                             input int n);
    chk("beat_count", 64'(beats.size()), 64'(n));
    for (int i = 0; i < n && i < beats.size(); i++) begin
      logic [AW-1:0] ea;
      logic [2:0]    ec;
      ea = AW'(32'(a) + 32'(i * BW));
      ec = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
      chk("beat_addr", beats[i].a, ea);
      chk("beat_we", beats[i].we, we);
      chk("beat_cti", beats[i].cti, ec);
      if (we) begin
        chk("beat_wdata", beats[i].d, wexp[i].d);
        chk("beat_wsel", beats[i].s, wexp[i].s);
      end else begin
        chk("beat_rsel", beats[i].s, 4'hF);
      end
    end
    chk("wdat_handshakes", 64'(wr_hs), we ? 64'(n) : 64'(0));
    chk("rdat_outstanding", 64'(rq.size()), 0);
  endtask

  vec_t tbl[4];
  int   d0;
  int   c0;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;

    tbl[0] = '{1'b1, 26'h40, 1, 1, -1, 0, 32'hDEADBEEF, 4'hF,
               3'b000, 3'b000, 3, 1, 26'h44};
    tbl[1] = '{1'b1, 26'h100, 4, 0, -1, 0, 32'h11111111, 4'hF,
               3'b010, 3'b111, 5, 1, 26'h110};
    tbl[2] = '{1'b1, 26'h100, 3, 0, 1, 5, 32'h22222222, 4'h3,
               3'b010, 3'b111, 9, 6, 26'h10C};
    tbl[3] = '{1'b0, 26'h3FFFFE0, 8, 0, -1, 0, 32'h0, 4'h0,
               3'b010, 3'b111, 8, 0, 26'h0};

    @(negedge clk);
    #1;
    chk("reset_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, busy, done, cmd_ready,
                       wdat_ready, rdat_valid}, 0);
    chk("reset_bus", {wb_cti_o, wb_sel_o, wb_addr_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 4; i++) begin
      setup(tbl[i].we, tbl[i].len, tbl[i].gi, tbl[i].gn, tbl[i].dly, 1'b0, 1'b0);
      if (tbl[i].we) begin
        wq[0].d   = tbl[i].d0;
        wq[0].s   = tbl[i].s0;
        wexp[0].d = tbl[i].d0;
        wexp[0].s = tbl[i].s0;
      end
      d0 = done_cnt;
      issue(tbl[i].we, tbl[i].a, LW'(tbl[i].len));
      wait_done(d0);
      check_model(tbl[i].we, tbl[i].a, tbl[i].len);
      if (beats.size() == tbl[i].len) begin
        chk("first_cti", beats[0].cti, tbl[i].c_first);
        chk("last_cti", beats[tbl[i].len - 1].cti, tbl[i].c_last);
      end
      chk("cyc_cycles", 64'(cyc_cnt), 64'(tbl[i].cyc));
      chk("stb_gap_cycles", 64'(gap_cnt), 64'(tbl[i].gapc));
      chk("done_after_cyc", 64'(done_at - last_hi), 1);
      chk("end_addr", wb_addr_o, tbl[i].end_a);
      chk("busy_in_fin", busy, 1);
      @(negedge clk);
      #2;
      chk("idle_after_fin", {busy, done, cmd_ready}, 3'b001);
      chk("done_once", 64'(done_cnt), 64'(d0 + 1));
    end

    // zero length followed by an immediate read
    setup(1'b0, 0, -1, 0, 0, 1'b0, 1'b0);
    d0 = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 26'h500;
    cmd_len   = '0;
    #2;
    chk("zl_ready", cmd_ready, 1);
    c0 = cyc_n;
    @(negedge clk);
    cmd_addr = 26'h600;
    cmd_len  = 8'd2;
    #2;
    chk("zl_fin_state", {cmd_ready, done, wb_cyc_o}, 3'b010);
    chk("zl_done_latency", 64'(done_at - c0), 1);
    chk("zl_no_cyc", 64'(cyc_cnt), 0);
    @(negedge clk);
    #2;
    chk("b2b_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(d0 + 1);
    check_model(1'b0, 26'h600, 2);

    // reset in the middle of a write burst
    setup(1'b1, 4, -1, 0, 1, 1'b0, 1'b0);
    d0 = done_cnt;
    issue(1'b1, 26'h200, 8'd4);
    for (int k = 0; k < 100 && beats.size() < 2; k++) begin
      @(negedge clk);
      #2;
    end
    @(posedge clk);
    #2;
    chk("cyc_before_reset", wb_cyc_o, 1);
    rst = 1'b1;
    #1;
    chk("reset_async_drop", {wb_cyc_o, wb_stb_o, busy}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("no_done_on_reset", 64'(done_cnt), 64'(d0));
    setup(1'b1, 1, -1, 0, 0, 1'b0, 1'b0);
    d0 = done_cnt;
    issue(1'b1, 26'h300, 8'd1);
    wait_done(d0);
    check_model(1'b1, 26'h300, 1);

    // random commands with random ack latency, gaps and stray acks
    for (int r = 0; r < 30; r++) begin
      bit            we;
      int            len;
      logic [AW-1:0] a;
      we  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      a   = AW'($urandom) & ~AW'(3);
      if ($urandom_range(0, 3) == 0) a = AW'(32'h3FFFFF0 + 4 * $urandom_range(0, 3));
      setup(we, len, -1, 0, $urandom_range(0, 2), 1'b1, 1'b1);
      d0 = done_cnt;
      issue(we, a, LW'(len));
      wait_done(d0);
      check_model(we, a, len);
    end

    spur_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
